ipgu_win_gen: RTL and testbench

IPGU_WIN_GEN -- requirements
Module: ipgu_win_gen

---
 rtl/ipgu_win_gen.sv | 167 ++++++++++++++++
 tb/tb_ipgu_win_gen.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipgu_win_gen.sv
// Sliding-window generator: fetches WIN x WIN pixel windows from a 1-cycle-latency RAM in
// raster order and presents them on a valid/ready handshake, fetching the next one in parallel.
module ipgu_win_gen #(
  parameter  int PIX_W   = 8,
  parameter  int MAX_DIM = 300,
  parameter  int WIN     = 20,
  parameter  int STRIDE  = 10,
  localparam int DIM_W   = $clog2(MAX_DIM + 1),
  localparam int CRD_W   = $clog2(MAX_DIM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     initWg,
  input  logic [DIM_W-1:0]         imgDim,
  input  logic                     abortWg,
  output logic                     rdyWg,
  output logic                     errWg,
  output logic                     ramRdEn,
  output logic [CRD_W-1:0]         ramAddrX,
  output logic [CRD_W-1:0]         ramAddrY,
  input  logic [PIX_W-1:0]         ramRdData,
  output logic                     vldWg,
  input  logic                     rdyHeu,
  output logic [WIN*WIN*PIX_W-1:0] winOut,
  output logic [CRD_W-1:0]         winRow,
  output logic [CRD_W-1:0]         winCol,
  output logic                     lastWin
);
  localparam int NPIX  = WIN * WIN;
  localparam int IDX_W = $clog2(NPIX);
  localparam int WB    = NPIX * PIX_W;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             rdy_q, rdy_d, err_q, err_d, rden_q, rden_d;
  logic             vld_q, vld_d, last_q, last_d, cap_q, cap_d, full_q, full_d;
  logic [CRD_W-1:0] ax_q, ax_d, ay_q, ay_d, wrow_q, wrow_d, wcol_q, wcol_d;
  logic [CRD_W-1:0] fr_q, fr_d, fc_q, fc_d, pr_q, pr_d, pc_q, pc_d, lim_q, lim_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [WB-1:0]    fbuf_q, fbuf_d, win_q, win_d;
  logic [DIM_W-1:0] span;
  logic             hs, cap_last, done, move, is_last;

  always_comb begin
    span     = imgDim - DIM_W'(WIN);
    hs       = vld_q & rdyHeu;
    cap_last = cap_q && (widx_q == IDX_W'(NPIX - 1));
    done     = cap_last || full_q;
    move     = done && (!vld_q || hs);
    is_last  = (fc_q == lim_q) && (fr_q == lim_q);

    state_d = state_q;  err_d  = 1'b0;   rden_d = rden_q;  vld_d  = vld_q;
    last_d  = last_q;   cap_d  = rden_q; full_d = full_q;  ax_d   = ax_q;
    ay_d    = ay_q;     wrow_d = wrow_q; wcol_d = wcol_q;  fr_d   = fr_q;
    fc_d    = fc_q;     pr_d   = pr_q;   pc_d   = pc_q;    lim_d  = lim_q;
    widx_d  = widx_q;   fbuf_d = fbuf_q; win_d  = win_q;

    // RAM data returns one cycle after the strobe, in issue order
    if (cap_q) begin
      fbuf_d[widx_q*PIX_W +: PIX_W] = ramRdData;
      widx_d = cap_last ? '0 : widx_q + IDX_W'(1);
    end

    if (rden_q) begin
      if (pc_q == CRD_W'(WIN - 1)) begin
        pc_d = '0;
        if (pr_q == CRD_W'(WIN - 1)) rden_d = 1'b0;
        else                         pr_d   = pr_q + CRD_W'(1);
      end else begin
        pc_d = pc_q + CRD_W'(1);
      end
      ax_d = fc_q + pc_d;
      ay_d = fr_q + pr_d;
    end

    if (cap_last && !move) full_d = 1'b1;

    // A completed fetch buffer moves out only when the output slot is free or being taken
    if (move) begin
      full_d = 1'b0;
      win_d  = fbuf_d;
      vld_d  = 1'b1;
      wrow_d = fr_q;
      wcol_d = fc_q;
      last_d = is_last;
      if (is_last) begin
        state_d = DRAIN;
      end else begin
        state_d = PRESENT;
        if (fc_q == lim_q) begin
          fc_d = '0;
          fr_d = fr_q + CRD_W'(STRIDE);
        end else begin
          fc_d = fc_q + CRD_W'(STRIDE);
        end
        pr_d   = '0;
        pc_d   = '0;
        rden_d = 1'b1;
        ax_d   = fc_d;
        ay_d   = fr_d;
      end
    end else if (hs) begin
      vld_d   = 1'b0;
      last_d  = 1'b0;
      state_d = (state_q == DRAIN) ? IDLE : FETCH;
    end

    if (state_q == IDLE && initWg) begin
      if (imgDim < DIM_W'(WIN) || imgDim > DIM_W'(MAX_DIM)) begin
        err_d = 1'b1;
      end else begin
        state_d = FETCH;
        lim_d   = CRD_W'((span / DIM_W'(STRIDE)) * DIM_W'(STRIDE));
        fc_d    = '0;
        fr_d    = '0;
        pr_d    = '0;
        pc_d    = '0;
        ax_d    = '0;
        ay_d    = '0;
        rden_d  = 1'b1;
        widx_d  = '0;
        full_d  = 1'b0;
      end
    end

    if (abortWg && state_q != IDLE) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      rden_d  = 1'b0;
      cap_d   = 1'b0;
      full_d  = 1'b0;
      widx_d  = '0;
    end

    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;  rdy_q  <= 1'b1; err_q  <= 1'b0; rden_q <= 1'b0;
      vld_q   <= 1'b0;  last_q <= 1'b0; cap_q  <= 1'b0; full_q <= 1'b0;
      ax_q    <= '0;    ay_q   <= '0;   wrow_q <= '0;   wcol_q <= '0;
      fr_q    <= '0;    fc_q   <= '0;   pr_q   <= '0;   pc_q   <= '0;
      lim_q   <= '0;    widx_q <= '0;   fbuf_q <= '0;   win_q  <= '0;
    end else begin
      state_q <= state_d; rdy_q  <= rdy_d;  err_q  <= err_d;  rden_q <= rden_d;
      vld_q   <= vld_d;   last_q <= last_d; cap_q  <= cap_d;  full_q <= full_d;
      ax_q    <= ax_d;    ay_q   <= ay_d;   wrow_q <= wrow_d; wcol_q <= wcol_d;
      fr_q    <= fr_d;    fc_q   <= fc_d;   pr_q   <= pr_d;   pc_q   <= pc_d;
      lim_q   <= lim_d;   widx_q <= widx_d; fbuf_q <= fbuf_d; win_q  <= win_d;
    end
  end

  assign rdyWg    = rdy_q;
  assign errWg    = err_q;
  assign ramRdEn  = rden_q;
  assign ramAddrX = ax_q;
  assign ramAddrY = ay_q;
  assign vldWg    = vld_q;
  assign winOut   = win_q;
  assign winRow   = wrow_q;
  assign winCol   = wcol_q;
  assign lastWin  = last_q;

endmodule

// File: tb/tb_ipgu_win_gen.sv
// Bench for ipgu_win_gen: synchronous RAM model, window-list scoreboard built from imgDim,
// and directed scenarios for timing, errors, backpressure, abort and reset.
`timescale 1ns/1ps
module tb_ipgu_win_gen;
  localparam int PIX_W   = 8;
  localparam int MAX_DIM = 300;
  localparam int WIN     = 20;
  localparam int STRIDE  = 10;
  localparam int DIM_W   = $clog2(MAX_DIM + 1);
  localparam int CRD_W   = $clog2(MAX_DIM);
  localparam int WB      = WIN * WIN * PIX_W;

  logic             clk = 1'b0, rst_n = 1'b1, initWg = 1'b0, abortWg = 1'b0, rdyHeu = 1'b1;
  logic [DIM_W-1:0] imgDim = '0;
  logic             rdyWg, errWg, ramRdEn, vldWg, lastWin;
  logic [CRD_W-1:0] ramAddrX, ramAddrY, winRow, winCol;
  logic [PIX_W-1:0] ramRdData = '0;
  logic [WB-1:0]    winOut;

  ipgu_win_gen #(.PIX_W(PIX_W), .MAX_DIM(MAX_DIM), .WIN(WIN), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .initWg(initWg), .imgDim(imgDim), .abortWg(abortWg),
    .rdyWg(rdyWg), .errWg(errWg), .ramRdEn(ramRdEn), .ramAddrX(ramAddrX),
    .ramAddrY(ramAddrY), .ramRdData(ramRdData), .vldWg(vldWg), .rdyHeu(rdyHeu),
    .winOut(winOut), .winRow(winRow), .winCol(winCol), .lastWin(lastWin)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int col; bit last; } exp_t;
  exp_t expq[$];
  exp_t e;

  int  total = 0, bad = 0, cyc = 0, t0 = 0, cur_dim = 0;
  int  rd_cnt = 0, rd_after = 0, first_rd_rel = -1, first_vld_rel = -1;
  int  vld_cyc = 0, err_cnt = 0, rdy_low = 0, hs_cnt = 0;
  bit  mon_en = 1'b0;
  int  hs_edge[1024], hs_row[1024], hs_col[1024], hs_last[1024];
  logic [WB-1:0] w0;

  function automatic logic [PIX_W-1:0] pix(input int x, input int y);
    int v;
    v = x * 5 + y * 11 + ((x ^ y) & 7) * 29;
    return v[PIX_W-1:0];
  endfunction

  function automatic int nwin(input int dim);
    return (dim - WIN) / STRIDE + 1;
  endfunction

  function automatic logic [WB-1:0] exp_win(input int row, input int col);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        w[(r*WIN + c)*PIX_W +: PIX_W] = pix(col + c, row + r);
    return w;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_pix(input int row, input int col);
    logic [WB-1:0] w;
    w = exp_win(row, col);
    total++;
    if (winOut !== w) begin
      bad++;
      for (int k = 0; k < WIN*WIN; k++)
        if (winOut[k*PIX_W +: PIX_W] !== w[k*PIX_W +: PIX_W]) begin
          $display("FAIL win_pixels at (%0d,%0d) pixel %0d: got %0h expected %0h",
                   row, col, k, winOut[k*PIX_W +: PIX_W], w[k*PIX_W +: PIX_W]);
          break;
        end
    end
  endtask

  task automatic load_model(input int dim);
    int n;
    n = nwin(dim);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        expq.push_back('{r * STRIDE, c * STRIDE, (r == n-1) && (c == n-1)});
  endtask

  // Synchronous RAM: data for a strobed address appears after the sampling edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ramRdData <= ramRdEn ? pix(int'(ramAddrX), int'(ramAddrY)) : PIX_W'($urandom);
  end

  // Sampled at negedge; "upcoming edge" is cyc+1
  always @(negedge clk) begin
    if (mon_en) begin
      if (initWg && rdyWg) t0 = cyc + 1;
      if (errWg) err_cnt++;
      if (!rdyWg) rdy_low++;
      if (vldWg) begin
        vld_cyc++;
        if (first_vld_rel < 0) first_vld_rel = cyc + 1 - t0;
        if (expq.size() == 0) begin
          chk("vld_unexpected", vldWg, 0);
        end else begin
          e = expq[0];
          chk("win_row", winRow, e.row);
          chk("win_col", winCol, e.col);
          chk("last_win", lastWin, e.last);
          chk_pix(e.row, e.col);
          if (rdyHeu) begin
            if (hs_cnt < 1024) begin
              hs_edge[hs_cnt] = cyc + 1;
              hs_row[hs_cnt]  = int'(winRow);
              hs_col[hs_cnt]  = int'(winCol);
              hs_last[hs_cnt] = int'(lastWin);
            end
            hs_cnt++;
            void'(expq.pop_front());
          end
        end
      end else begin
        chk("last_without_vld", lastWin, 0);
      end
      if (ramRdEn) begin
        rd_cnt++;
        if (first_vld_rel >= 0) rd_after++;
        if (first_rd_rel < 0) first_rd_rel = cyc + 1 - t0;
        chk("addr_in_image", (int'(ramAddrX) < cur_dim) && (int'(ramAddrY) < cur_dim), 1);
      end
    end
  end

  task automatic start(input int dim);
    @(posedge clk); #1;
    rd_cnt = 0; rd_after = 0; first_rd_rel = -1; first_vld_rel = -1;
    vld_cyc = 0; err_cnt = 0; rdy_low = 0; hs_cnt = 0;
    cur_dim = dim;
    if (dim >= WIN && dim <= MAX_DIM) load_model(dim);
    imgDim = DIM_W'(dim);
    initWg = 1'b1;
    @(posedge clk); #1;
    initWg = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (!(rdyWg === 1'b1 && expq.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  task automatic wait_vld(input int budget, input string tag);
    int n;
    n = 0;
    while (vldWg !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdyWg", rdyWg, 1);
    chk("rst_vldWg", vldWg, 0);
    chk("rst_errWg", errWg, 0);
    chk("rst_ramRdEn", ramRdEn, 0);
    chk("rst_lastWin", lastWin, 0);
    chk("rst_addrX", ramAddrX, 0);
    chk("rst_winRow", winRow, 0);
    chk("rst_winOut_zero", winOut == '0, 1);

    chk("model_n300", nwin(300) * nwin(300), 841);
    chk("model_n65", nwin(65) * nwin(65), 25);
    chk("model_n40", nwin(40) * nwin(40), 9);
    chk("model_n20", nwin(20) * nwin(20), 1);

    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;

    // Rejected dimensions
    start(19);
    repeat (20) @(negedge clk);
    chk("err19_pulses", err_cnt, 1);
    chk("err19_reads", rd_cnt, 0);
    chk("err19_vld", vld_cyc, 0);
    chk("err19_rdy_low", rdy_low, 0);
    start(301);
    repeat (20) @(negedge clk);
    chk("err301_pulses", err_cnt, 1);
    chk("err301_reads", rd_cnt, 0);
    chk("err301_vld", vld_cyc, 0);
    chk("err301_rdy_low", rdy_low, 0);

    // Single-window image: latency
    rdyHeu = 1'b1;
    start(20);
    wait_idle(2000, "idle20_timeout");
    chk("d20_first_read_edge", first_rd_rel, 1);
    chk("d20_first_vld_edge", first_vld_rel, 402);
    chk("d20_windows", hs_cnt, 1);
    chk("d20_last_flag", hs_last[0], 1);
    chk("d20_reads", rd_cnt, 400);

    // 5x5 windows
    start(65);
    wait_idle(15000, "idle65_timeout");
    chk("d65_windows", hs_cnt, 25);
    chk("d65_last_row", hs_row[24], 40);
    chk("d65_last_col", hs_col[24], 40);
    chk("d65_last_flag", hs_last[24], 1);
    chk("d65_reads", rd_cnt, 10000);

    // Backpressure: hold the consumer off for 1000 cycles
    rdyHeu = 1'b0;
    start(40);
    wait_vld(1000, "stall_vld_timeout");
    @(posedge clk); #1;
    w0 = winOut;
    chk("stall_first_vld_edge", first_vld_rel, 402);
    repeat (1000) @(posedge clk);
    #1;
    total++;
    if (winOut !== w0) begin
      bad++;
      $display("FAIL stall_winout_stable: window data changed while held");
    end
    chk("stall_vld_held", vldWg, 1);
    chk("stall_reads_after_vld", rd_after, 400);
    chk("stall_reads_total", rd_cnt, 800);
    chk("stall_no_transfer", hs_cnt, 0);
    rdyHeu = 1'b1;
    wait_idle(6000, "idle40_timeout");
    chk("stall_windows", hs_cnt, 9);
    chk("stall_b2b_edges", hs_edge[1] - hs_edge[0], 1);
    chk("stall_second_col", hs_col[1], 10);
    chk("stall_second_row", hs_row[1], 0);

    // Full-size image: run past the first row wrap, then abort while a window is presented
    rdyHeu = 1'b1;
    start(300);
    n = 0;
    while (hs_cnt < 30 && n < 15000) begin
      @(negedge clk);
      n++;
    end
    chk("d300_progress_timeout", n < 15000, 1);
    @(posedge clk); #1 rdyHeu = 1'b0;
    chk("d300_row0_last_col", hs_col[28], 280);
    chk("d300_wrap_row", hs_row[29], 10);
    chk("d300_wrap_col", hs_col[29], 0);
    wait_vld(1000, "abort_vld_timeout");
    repeat (50) @(posedge clk);
    #1;
    chk("abort_pre_vld", vldWg, 1);
    abortWg = 1'b1;
    @(posedge clk); #1;
    abortWg = 1'b0;
    chk("abort_vld", vldWg, 0);
    chk("abort_rdy", rdyWg, 1);
    chk("abort_ramRdEn", ramRdEn, 0);
    expq.delete();
    rdyHeu = 1'b1;
    start(40);
    wait_idle(6000, "after_abort_timeout");
    chk("after_abort_windows", hs_cnt, 9);
    chk("after_abort_reads", rd_cnt, 3600);
    chk("after_abort_last_row", hs_row[8], 20);

    // Asynchronous reset mid-presentation
    rdyHeu = 1'b0;
    start(40);
    wait_vld(1000, "prereset_vld_timeout");
    repeat (5) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", vldWg, 0);
    chk("midrst_ramRdEn", ramRdEn, 0);
    chk("midrst_rdy", rdyWg, 1);
    chk("midrst_lastWin", lastWin, 0);
    chk("midrst_winOut_zero", winOut == '0, 1);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd_cnt = 0;
    vld_cyc = 0;
    rdyHeu = 1'b1;
    mon_en = 1'b1;
    repeat (500) @(negedge clk);
    chk("postrst_vld", vld_cyc, 0);
    chk("postrst_reads", rd_cnt, 0);
    start(20);
    wait_idle(2000, "postrst_idle_timeout");
    chk("postrst_windows", hs_cnt, 1);
    chk("postrst_first_vld_edge", first_vld_rel, 402);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
